writeback_stage: RTL and testbench

- Final pipeline stage of the RV64 core. Latches the MEM-stage bundle and produces the writeback bus consumed by decode's register file, CSR file and forwarding muxes: WB_IR, WB_RFD, WB_CSRFD, WB_ST_REG, WB_ST_CSR, WB_CS, WB_CAUSE, WB_ALU_RESULT, WB_MEM_RESULT.
- Performs load-data extraction and sign extension, selects the result, computes the new CSR value, and sequences trap entry through a small FSM that flushes the pipe.

---
 rtl/rv_pkg.sv | 49 ++++
 rtl/writeback_stage_if.sv | 50 +++++
 rtl/load_extract.sv | 33 +++
 rtl/writeback_stage.sv | 181 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV64 definitions for the writeback stage: opcode and trap-cause
// constants, the trap-sequencing FSM state type and opcode classification helpers.
package rv_pkg;

  localparam int RV_XLEN = 64;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

  localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

  localparam logic [RV_XLEN-1:0] CAUSE_ILLEGAL    = 64'd2;
  localparam logic [RV_XLEN-1:0] CAUSE_ECALL_BASE = 64'd8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } wb_state_e;

  function automatic logic opc_supported(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP, OPC_OPIMM, OPC_OP32, OPC_OPIMM32, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_FENCE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // SYSTEM only writes rd for the CSR forms; ECALL/EBREAK share funct3 000.
  function automatic logic opc_writes_rd(input logic [6:0] opc, input logic [2:0] funct3);
    case (opc)
      OPC_LOAD, OPC_OP, OPC_OPIMM, OPC_OP32, OPC_OPIMM32, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR: return 1'b1;
      OPC_SYSTEM:        return (funct3[1:0] != 2'b00);
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Writeback-stage bus: MEM-stage bundle in, writeback results out.
// WB_INSTRET exists only when WB_INSTRET_EN is defined.
interface writeback_stage_if;
  import rv_pkg::*;

  logic               MEM_V;
  logic [31:0]        MEM_IR;
  logic [RV_XLEN-1:0] MEM_NPC;
  logic [RV_XLEN-1:0] MEM_ALU_RESULT;
  logic [RV_XLEN-1:0] MEM_RDATA;
  logic [RV_XLEN-1:0] MEM_CSR_OLD;
  logic [RV_XLEN-1:0] MEM_CSR_SRC;
  logic [1:0]         PRIVILEGE;

  logic               WB_V;
  logic [31:0]        WB_IR;
  logic [RV_XLEN-1:0] WB_RFD;
  logic [RV_XLEN-1:0] WB_CSRFD;
  logic [RV_XLEN-1:0] WB_ALU_RESULT;
  logic [RV_XLEN-1:0] WB_MEM_RESULT;
  logic               WB_ST_REG;
  logic               WB_ST_CSR;
  logic               WB_CS;
  logic [RV_XLEN-1:0] WB_CAUSE;
  logic               WB_FLUSH;
`ifdef WB_INSTRET_EN
  logic [RV_XLEN-1:0] WB_INSTRET;
`endif

  modport master (
    output MEM_V, MEM_IR, MEM_NPC, MEM_ALU_RESULT, MEM_RDATA, MEM_CSR_OLD,
           MEM_CSR_SRC, PRIVILEGE,
    input  WB_V, WB_IR, WB_RFD, WB_CSRFD, WB_ALU_RESULT, WB_MEM_RESULT,
           WB_ST_REG, WB_ST_CSR, WB_CS, WB_CAUSE, WB_FLUSH
`ifdef WB_INSTRET_EN
    , input WB_INSTRET
`endif
  );

  modport slave (
    input  MEM_V, MEM_IR, MEM_NPC, MEM_ALU_RESULT, MEM_RDATA, MEM_CSR_OLD,
           MEM_CSR_SRC, PRIVILEGE,
    output WB_V, WB_IR, WB_RFD, WB_CSRFD, WB_ALU_RESULT, WB_MEM_RESULT,
           WB_ST_REG, WB_ST_CSR, WB_CS, WB_CAUSE, WB_FLUSH
`ifdef WB_INSTRET_EN
    , output WB_INSTRET
`endif
  );

endinterface

// File: rtl/load_extract.sv
// Combinational load-data lane select and sign/zero extension from an aligned
// doubleword; misaligned addresses simply use the truncated lane.
module load_extract
  import rv_pkg::*;
(
  input  logic [2:0]         i_funct3,
  input  logic [2:0]         i_addr,
  input  logic [RV_XLEN-1:0] i_rdata,
  output logic [RV_XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr[2:1], 4'b0000} +: 16];
  assign w_word = i_rdata[{i_addr[2], 5'b00000} +: 32];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      3'b000:  o_data = {{(RV_XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  o_data = {{(RV_XLEN-8){1'b0}}, w_byte};
      3'b001:  o_data = {{(RV_XLEN-16){w_half[15]}}, w_half};
      3'b101:  o_data = {{(RV_XLEN-16){1'b0}}, w_half};
      3'b010:  o_data = {{(RV_XLEN-32){w_word[31]}}, w_word};
      3'b110:  o_data = {{(RV_XLEN-32){1'b0}}, w_word};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV64 writeback stage: registers the MEM bundle into the writeback bus and
// sequences trap entry with a flush FSM. Define WB_INSTRET_EN for WB_INSTRET.
module writeback_stage
  import rv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 3,
  parameter int XLEN         = 64
) (
  input logic              CLK,
  input logic              RESET_N,
  writeback_stage_if.slave bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_load_data;

  assign w_opcode = bus.MEM_IR[6:0];
  assign w_rd     = bus.MEM_IR[11:7];
  assign w_funct3 = bus.MEM_IR[14:12];
  assign w_rs1    = bus.MEM_IR[19:15];

  load_extract u_load_extract (
    .i_funct3 (w_funct3),
    .i_addr   (bus.MEM_ALU_RESULT[2:0]),
    .i_rdata  (bus.MEM_RDATA),
    .o_data   (w_load_data)
  );

  wb_state_e       r_state;
  wb_state_e       w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;

  logic            w_is_csr;
  logic            w_is_ecall;
  logic            w_acc;
  logic            w_trap;
  logic            w_commit;
  logic            w_st_reg;
  logic            w_st_csr;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_rfd;
  logic [XLEN-1:0] w_csr_new;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_is_csr   = (w_opcode == OPC_SYSTEM) && (w_funct3[1:0] != 2'b00);
    w_is_ecall = (bus.MEM_IR == INSN_ECALL);
    w_acc      = bus.MEM_V && (r_state == ST_IDLE);
    w_trap     = w_acc && (w_is_ecall || !opc_supported(w_opcode));
    w_commit   = w_acc && !w_trap;
    w_st_reg   = w_commit && opc_writes_rd(w_opcode, w_funct3) && (w_rd != 5'd0);
    // CSRRS/CSRRC with rs1/uimm = 0 are pure reads and must not write the CSR.
    w_st_csr   = w_commit && w_is_csr && !(w_funct3[1] && (w_rs1 == 5'd0));
    w_cause    = w_is_ecall ? (CAUSE_ECALL_BASE + {{(XLEN-2){1'b0}}, bus.PRIVILEGE})
                            : CAUSE_ILLEGAL;

    w_rfd = bus.MEM_ALU_RESULT;
    if (w_opcode == OPC_LOAD) begin
      w_rfd = w_load_data;
    end else if ((w_opcode == OPC_JAL) || (w_opcode == OPC_JALR)) begin
      w_rfd = bus.MEM_NPC;
    end else if ((w_opcode == OPC_SYSTEM) && (w_funct3 != 3'b000)) begin
      w_rfd = bus.MEM_CSR_OLD;
    end

    w_csr_new = bus.MEM_CSR_OLD;
    case (w_funct3[1:0])
      2'b01:   w_csr_new = bus.MEM_CSR_SRC;
      2'b10:   w_csr_new = bus.MEM_CSR_OLD | bus.MEM_CSR_SRC;
      2'b11:   w_csr_new = bus.MEM_CSR_OLD & ~bus.MEM_CSR_SRC;
      default: w_csr_new = bus.MEM_CSR_OLD;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_trap) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
    endcase
  end

  // NOTE: state and outputs use <= so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  logic            r_v;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_rfd;
  logic [XLEN-1:0] r_csrfd;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_mem;
  logic            r_st_reg;
  logic            r_st_csr;
  logic            r_cs;
  logic [XLEN-1:0] r_cause;
  logic            r_flush;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_v      <= 1'b0;
      r_ir     <= '0;
      r_rfd    <= '0;
      r_csrfd  <= '0;
      r_alu    <= '0;
      r_mem    <= '0;
      r_st_reg <= 1'b0;
      r_st_csr <= 1'b0;
      r_cs     <= 1'b0;
      r_cause  <= '0;
      r_flush  <= 1'b0;
    end else begin
      r_v      <= w_acc;
      r_ir     <= bus.MEM_IR;
      r_rfd    <= w_rfd;
      r_csrfd  <= w_csr_new;
      r_alu    <= bus.MEM_ALU_RESULT;
      r_mem    <= w_load_data;
      r_st_reg <= w_st_reg;
      r_st_csr <= w_st_csr;
      r_cs     <= w_trap;
      r_flush  <= (w_state_nxt == ST_FLUSH);
      if (w_trap) begin
        r_cause <= w_cause;
      end
    end
  end

  assign bus.WB_V          = r_v;
  assign bus.WB_IR         = r_ir;
  assign bus.WB_RFD        = r_rfd;
  assign bus.WB_CSRFD      = r_csrfd;
  assign bus.WB_ALU_RESULT = r_alu;
  assign bus.WB_MEM_RESULT = r_mem;
  assign bus.WB_ST_REG     = r_st_reg;
  assign bus.WB_ST_CSR     = r_st_csr;
  assign bus.WB_CS         = r_cs;
  assign bus.WB_CAUSE      = r_cause;
  assign bus.WB_FLUSH      = r_flush;

`ifdef WB_INSTRET_EN
  logic [XLEN-1:0] r_instret;

  // Counts retirements as seen on the registered bus, so it trails WB_V by a cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_instret <= '0;
    end else if (r_v && !r_cs) begin
      r_instret <= r_instret + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  assign bus.WB_INSTRET = r_instret;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push hand-computed
// expectations; a monitor pops and compares on every retiring cycle.
module tb_writeback_stage;

  logic clk;
  logic rst_n;

  writeback_stage_if bus ();

  writeback_stage #(
    .FLUSH_CYCLES (3),
    .XLEN         (64)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic [63:0] alu;
    logic [63:0] rfd;
    bit          chk_rfd;
    logic [63:0] csrfd;
    bit          chk_csr;
    logic [63:0] memr;
    bit          chk_mem;
    logic        st_reg;
    logic        st_csr;
    logic        cs;
    logic [63:0] cause;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_fail;
  logic [63:0] cur_cause;
  logic [63:0] exp_instret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] rdata,
                       input logic [63:0] npc, input logic [63:0] old, input logic [63:0] src,
                       input logic [1:0] priv);
    bus.MEM_V          = 1'b1;
    bus.MEM_IR         = ir;
    bus.MEM_ALU_RESULT = alu;
    bus.MEM_RDATA      = rdata;
    bus.MEM_NPC        = npc;
    bus.MEM_CSR_OLD    = old;
    bus.MEM_CSR_SRC    = src;
    bus.PRIVILEGE      = priv;
  endtask

  task automatic issue(input string tag, input logic [31:0] ir, input logic [63:0] alu,
                       input logic [63:0] rdata, input logic [63:0] npc, input logic [63:0] old,
                       input logic [63:0] src, input logic [63:0] rfd_e, input logic st_reg_e,
                       input logic st_csr_e, input logic [63:0] csrfd_e);
    exp_t e;
    @(negedge clk);
    drive(ir, alu, rdata, npc, old, src, 2'd0);
    e.tag     = tag;
    e.ir      = ir;
    e.alu     = alu;
    e.rfd     = rfd_e;
    e.chk_rfd = 1'b1;
    e.csrfd   = csrfd_e;
    e.chk_csr = (ir[6:0] == 7'h73) && (ir[13:12] != 2'b00);
    e.memr    = rfd_e;
    e.chk_mem = (ir[6:0] == 7'h03);
    e.st_reg  = st_reg_e;
    e.st_csr  = st_csr_e;
    e.cs      = 1'b0;
    e.cause   = cur_cause;
    exp_q.push_back(e);
    exp_instret++;
  endtask

  task automatic issue_trap(input string tag, input logic [31:0] ir, input logic [63:0] alu,
                            input logic [1:0] priv, input logic [63:0] cause_e);
    exp_t e;
    @(negedge clk);
    drive(ir, alu, 64'h0, 64'h0, 64'h0, 64'h0, priv);
    cur_cause = cause_e;
    e.tag     = tag;
    e.ir      = ir;
    e.alu     = alu;
    e.rfd     = 64'h0;
    e.chk_rfd = 1'b0;
    e.csrfd   = 64'h0;
    e.chk_csr = 1'b0;
    e.memr    = 64'h0;
    e.chk_mem = 1'b0;
    e.st_reg  = 1'b0;
    e.st_csr  = 1'b0;
    e.cs      = 1'b1;
    e.cause   = cause_e;
    exp_q.push_back(e);
  endtask

  // Presents a valid instruction that must be ignored (nothing expected).
  task automatic drive_flushed(input logic [31:0] ir, input logic [63:0] alu);
    @(negedge clk);
    drive(ir, alu, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.MEM_V = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, ".v"},      64'(bus.WB_V), 64'h0);
    check({pfx, ".ir"},     64'(bus.WB_IR), 64'h0);
    check({pfx, ".rfd"},    bus.WB_RFD, 64'h0);
    check({pfx, ".csrfd"},  bus.WB_CSRFD, 64'h0);
    check({pfx, ".alu"},    bus.WB_ALU_RESULT, 64'h0);
    check({pfx, ".mem"},    bus.WB_MEM_RESULT, 64'h0);
    check({pfx, ".st_reg"}, 64'(bus.WB_ST_REG), 64'h0);
    check({pfx, ".st_csr"}, 64'(bus.WB_ST_CSR), 64'h0);
    check({pfx, ".cs"},     64'(bus.WB_CS), 64'h0);
    check({pfx, ".cause"},  bus.WB_CAUSE, 64'h0);
    check({pfx, ".flush"},  64'(bus.WB_FLUSH), 64'h0);
  endtask

  initial begin : monitor
    exp_t e;
    int   run;
    logic prev_cs;
    logic prev_flush;
    run        = 0;
    prev_cs    = 1'b0;
    prev_flush = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        run        = 0;
        prev_cs    = 1'b0;
        prev_flush = 1'b0;
        continue;
      end
      if (bus.WB_V) begin
        check("retire_expected", 64'(exp_q.size() != 0), 64'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({e.tag, ".ir"},     64'(bus.WB_IR), 64'(e.ir));
          check({e.tag, ".alu"},    bus.WB_ALU_RESULT, e.alu);
          check({e.tag, ".st_reg"}, 64'(bus.WB_ST_REG), 64'(e.st_reg));
          check({e.tag, ".st_csr"}, 64'(bus.WB_ST_CSR), 64'(e.st_csr));
          check({e.tag, ".cs"},     64'(bus.WB_CS), 64'(e.cs));
          check({e.tag, ".cause"},  bus.WB_CAUSE, e.cause);
          check({e.tag, ".flush"},  64'(bus.WB_FLUSH), 64'(e.cs));
          if (e.chk_rfd) check({e.tag, ".rfd"},   bus.WB_RFD, e.rfd);
          if (e.chk_csr) check({e.tag, ".csrfd"}, bus.WB_CSRFD, e.csrfd);
          if (e.chk_mem) check({e.tag, ".mem"},   bus.WB_MEM_RESULT, e.memr);
        end
      end else begin
        check("idle_strobes", {61'h0, bus.WB_ST_REG, bus.WB_ST_CSR, bus.WB_CS}, 64'h0);
      end
      if (bus.WB_CS) check("cs_single_pulse", 64'(prev_cs), 64'h0);
      if (bus.WB_FLUSH) begin
        run++;
      end else if (prev_flush) begin
        check("flush_length", 64'(run), 64'd3);
        run = 0;
      end
      prev_cs    = bus.WB_CS;
      prev_flush = bus.WB_FLUSH;
    end
  end

  initial begin : stimulus
    n_checks    = 0;
    n_fail      = 0;
    cur_cause   = 64'h0;
    exp_instret = 64'h0;
    bus.MEM_V = 1'b0;
    drive(32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0);
    bus.MEM_V = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads: lane select, extension, misaligned truncation.
    issue("lb",   32'h00008283, 64'h1003, 64'h00000000_80FF0000, 64'h0, 64'h0, 64'h0,
          64'hFFFFFFFF_FFFFFF80, 1'b1, 1'b0, 64'h0);
    issue("lbu",  32'h0000C283, 64'h1002, 64'h00000000_80FF0000, 64'h0, 64'h0, 64'h0,
          64'h00000000_000000FF, 1'b1, 1'b0, 64'h0);
    issue("lh",   32'h00009283, 64'h1006, 64'h8001_0000_0000_0000, 64'h0, 64'h0, 64'h0,
          64'hFFFFFFFF_FFFF8001, 1'b1, 1'b0, 64'h0);
    issue("lhu",  32'h0000D283, 64'h1006, 64'h8001_0000_0000_0000, 64'h0, 64'h0, 64'h0,
          64'h00000000_00008001, 1'b1, 1'b0, 64'h0);
    issue("lw",   32'h0000A283, 64'h1004, 64'h87654321_00000000, 64'h0, 64'h0, 64'h0,
          64'hFFFFFFFF_87654321, 1'b1, 1'b0, 64'h0);
    issue("lwu",  32'h0000E283, 64'h1004, 64'h87654321_00000000, 64'h0, 64'h0, 64'h0,
          64'h00000000_87654321, 1'b1, 1'b0, 64'h0);
    issue("ld",   32'h0000B283, 64'h1000, 64'h01234567_89ABCDEF, 64'h0, 64'h0, 64'h0,
          64'h01234567_89ABCDEF, 1'b1, 1'b0, 64'h0);
    issue("lw_mis", 32'h0000A283, 64'h1003, 64'h87654321_12345678, 64'h0, 64'h0, 64'h0,
          64'h00000000_12345678, 1'b1, 1'b0, 64'h0);

    // Integer, jumps, no-write classes.
    issue("addi_x0", 32'h00508013, 64'h6, 64'h0, 64'h0, 64'h0, 64'h0, 64'h6, 1'b0, 1'b0, 64'h0);
    issue("add",   32'h002081B3, 64'h30, 64'h0, 64'h0, 64'h0, 64'h0, 64'h30, 1'b1, 1'b0, 64'h0);
    issue("addw",  32'h002081BB, 64'h7, 64'h0, 64'h0, 64'h0, 64'h0, 64'h7, 1'b1, 1'b0, 64'h0);
    issue("addiw", 32'h0050819B, 64'h8, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8, 1'b1, 1'b0, 64'h0);
    issue("auipc", 32'h00001197, 64'h9, 64'h0, 64'h0, 64'h0, 64'h0, 64'h9, 1'b1, 1'b0, 64'h0);
    issue("lui",   32'h12345337, 64'h12345000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h12345000,
          1'b1, 1'b0, 64'h0);
    issue("jal",   32'h000000EF, 64'h3000, 64'h0, 64'h2004, 64'h0, 64'h0, 64'h2004,
          1'b1, 1'b0, 64'h0);
    issue("jalr",  32'h000280E7, 64'h4000, 64'h0, 64'h3008, 64'h0, 64'h0, 64'h3008,
          1'b1, 1'b0, 64'h0);
    issue("sd",    32'h0020B023, 64'h1008, 64'h0, 64'h0, 64'h0, 64'h0, 64'h1008, 1'b0, 1'b0, 64'h0);
    issue("beq",   32'h00208063, 64'h1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h1, 1'b0, 1'b0, 64'h0);
    issue("fence", 32'h0000000F, 64'h2, 64'h0, 64'h0, 64'h0, 64'h0, 64'h2, 1'b0, 1'b0, 64'h0);

    // CSR forms: read-only RS, RC, RW to x0, immediate RS.
    issue("csrrs_x0", 32'h300023F3, 64'h0, 64'h0, 64'h0, 64'h5, 64'h0, 64'h5, 1'b1, 1'b0, 64'h5);
    issue("csrrc",    32'h300133F3, 64'h0, 64'h0, 64'h0, 64'h5, 64'h4, 64'h5, 1'b1, 1'b1, 64'h1);
    issue("csrrw_x0", 32'h30011073, 64'h0, 64'h0, 64'h0, 64'h5, 64'hAA, 64'h5,
          1'b0, 1'b1, 64'hAA);
    issue("csrrsi",   32'h3001E273, 64'h0, 64'h0, 64'h0, 64'h10, 64'h3, 64'h10,
          1'b1, 1'b1, 64'h13);

    // ECALL from M-mode, then valid ADDs during the flush that must not retire.
    issue_trap("ecall", 32'h00000073, 64'h0BAD, 2'd3, 64'd11);
    drive_flushed(32'h002081B3, 64'hDEAD1);
    drive_flushed(32'h002081B3, 64'hDEAD2);
    drive_flushed(32'h002081B3, 64'hDEAD3);
    issue("add_post", 32'h002081B3, 64'h31, 64'h0, 64'h0, 64'h0, 64'h0, 64'h31, 1'b1, 1'b0, 64'h0);
    idle();

    // Illegal opcode, then reset in the middle of its flush.
    issue_trap("illegal", 32'h0000027F, 64'h77, 2'd0, 64'd2);
    idle();
    @(negedge clk);
    check("pre_rst_flush", 64'(bus.WB_FLUSH), 64'h1);
    #1 rst_n = 1'b0;
    cur_cause   = 64'h0;
    exp_instret = 64'h0;
    #1 check_all_zero("mid_flush_rst");
    @(negedge clk);
    rst_n = 1'b1;
    issue("addi_after_rst", 32'h00508113, 64'h55, 64'h0, 64'h0, 64'h0, 64'h0, 64'h55,
          1'b1, 1'b0, 64'h0);
    idle();
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
`ifdef WB_INSTRET_EN
    idle();
    check("instret", bus.WB_INSTRET, exp_instret);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
